dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
- Data-side memory stage sitting directly downstream of the single-cycle CPU core.
- Consumes the core's memread/memwrite/mem_addr/mem_writedata and returns mem_readdata in the same cycle.
- Backs addresses with a word-addressed data RAM plus a small MMIO window:
  - byte-wide console TX FIFO with ready/valid drain
  - free-running cycle counter
  - sticky fault register

Parameters:
- DMEM_WORDS, 1024: data RAM depth in 32-bit words; power of two.
- TXFIFO_DEPTH, 8: TX FIFO entries; power of two, 2..16.
- MMIO_BASE, 32'hFFFF_0000: base of the 16-byte MMIO window.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memread  in  1  core load request this cycle.
- memwrite  in  1  core store request this cycle.
- mem_addr  in  32  byte address from core ALU.
- mem_writedata  in  32  store data.
- mem_readdata  out  32  load data, combinational from current-cycle inputs.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts head this cycle.

Behaviour:
- Reset (reset=0, async): FIFO empty (tx_valid=0, tx_data=0), cycle counter=0, fault=0. RAM contents are not reset.
- Address decode, first match wins:
  - addr[1:0]!=0: misaligned.
  - MMIO_BASE <= addr < MMIO_BASE+16: MMIO.
  - addr < DMEM_WORDS*4: RAM.
  - else: out-of-range.
- RAM read: combinational. mem_readdata = ram[addr[log2(DMEM_WORDS)+1:2]] when memread=1.
- RAM write: registered on posedge when memwrite=1. Read of the same word in the same cycle returns the old value.
- mem_readdata=0 whenever memread=0, or for misaligned/out-of-range accesses. Misaligned and out-of-range writes are dropped.
- MMIO register map, offsets from MMIO_BASE:
  - +0x0 TXDATA: W pushes mem_writedata[7:0]; R returns 0.
  - +0x4 TXSTATUS: R returns {count in [8:4], empty [1], full [0]}, zero-extended; W ignored.
  - +0x8 CYCLES: R returns counter; W loads mem_writedata.
  - +0xC FAULT: R returns sticky flags; W of any value clears all flags.
- Counter:
  - Increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - A write loads the written value at that edge, with no increment on that edge. A read in the next cycle returns the loaded value.
- FIFO:
  - First-word-fall-through: tx_data = head, tx_valid = !empty.
  - Pop when tx_valid && tx_ready.
  - Push when a TXDATA write occurs and (!full || pop this cycle). Push and pop in the same cycle leave count unchanged.
  - Push while full with no pop: byte dropped, FAULT[3] set.
  - Pointers wrap modulo TXFIFO_DEPTH. count ranges 0..TXFIFO_DEPTH.
- FAULT bits, sticky, set on the posedge after the offending cycle:
  - [0] misaligned access
  - [1] out-of-range access
  - [2] memread && memwrite together; treated as a write, mem_readdata=0
  - [3] TX overflow
- FAULT set/clear priority: a FAULT write clears all bits; a fault raised in that same cycle still sets.
- Reset asserted mid-drain: FIFO contents lost; tx_valid drops asynchronously.

Decomposition:
- Package mmio_pkg holds:
  - MMIO offset constants: OFF_TXDATA, OFF_TXSTATUS, OFF_CYCLES, OFF_FAULT.
  - FAULT bit indices: FLT_MISALIGN, FLT_RANGE, FLT_RW, FLT_OVF.
  - Enum typedef for decoded region: REG_RAM, REG_MMIO, REG_BAD.
- Sub-module sync_fifo, parameterised width/depth:
  - push/pop/full/empty/count interface.
  - Holds the full-with-pop accept rule.
- Top level holds decode, RAM, counter and FAULT.

Test Plan:
- RAM round trip: write 32'hDEADBEEF to 0x40, then read 0x40 -> mem_readdata=32'hDEADBEEF. Read 0x44 (never written, preloaded 0) -> 0.
- Misaligned and out-of-range: write to 0x41, then read FAULT -> 32'h1. Write FAULT, then read 0x0000_1000 with DMEM_WORDS=1024 -> mem_readdata=0 and FAULT=32'h2.
- TX FIFO with tx_ready=0:
  - Push 'A'..'H': TXSTATUS reads 32'h81 (count=8, full).
  - Push 'I': FAULT[3]=1 and the FIFO is unchanged.
  - Raise tx_ready: 'A'..'H' drain on consecutive cycles, then tx_valid=0 and TXSTATUS=32'h2.
- FIFO at boundary: full with tx_ready=1 and a push of 'Z' in the same cycle -> count stays 8 and 'Z' emerges last. No FAULT[3].
- Counter: write CYCLES=32'hFFFF_FFFE -> reads 32'hFFFF_FFFE, then FFFF_FFFF, then 0 on successive cycles.
- Async reset mid-operation: 3 bytes queued and counter=100, pulse reset low between edges -> tx_valid=0, CYCLES reads 0, FAULT=0. RAM word at 0x40 retains 32'hDEADBEEF.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and decode helper for the data-memory / MMIO stage.
package mmio_pkg;

   localparam logic [3:0] OFF_TXDATA   = 4'h0;
   localparam logic [3:0] OFF_TXSTATUS = 4'h4;
   localparam logic [3:0] OFF_CYCLES   = 4'h8;
   localparam logic [3:0] OFF_FAULT    = 4'hC;

   localparam int FLT_MISALIGN = 0;
   localparam int FLT_RANGE    = 1;
   localparam int FLT_RW       = 2;
   localparam int FLT_OVF      = 3;

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_MMIO = 2'd1,
      REG_BAD  = 2'd2
   } region_e;

   // First match wins: misaligned, then the 16-byte MMIO window, then RAM.
   function automatic region_e decode_region(input logic [31:0] addr,
                                             input logic [27:0] mmio_page,
                                             input logic [32:0] ram_bytes);
      if (addr[1:0] != 2'b00)         return REG_BAD;
      if (addr[31:4] == mmio_page)    return REG_MMIO;
      if ({1'b0, addr} < ram_bytes)   return REG_RAM;
      return REG_BAD;
   endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Core-side load/store bus plus the console TX drain channel.
interface dmem_mmio_if;
   // TX channel: tx_data/tx_valid are held stable until the cycle in which
   // tx_ready is also high; that cycle transfers exactly one byte.
   logic        memread;
   logic        memwrite;
   logic [31:0] mem_addr;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport slave (
      input  memread, memwrite, mem_addr, mem_writedata, tx_ready,
      output mem_readdata, tx_data, tx_valid
   );

   modport master (
      output memread, memwrite, mem_addr, mem_writedata, tx_ready,
      input  mem_readdata, tx_data, tx_valid
   );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is reported as dropped.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_drop
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_data  = o_empty ? '0 : r_mem[r_rptr];

   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_drop  = i_push & ~w_push;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory stage: word RAM plus MMIO window (TX FIFO, cycle counter,
// sticky fault flags). Loads are answered combinationally in the same cycle.
module dmem_mmio
   import mmio_pkg::*;
#(
   parameter int          DMEM_WORDS   = 1024,
   parameter int          TXFIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   dmem_mmio_if.slave  bus
);
   localparam int          AW        = $clog2(DMEM_WORDS);
   localparam int          CW        = $clog2(TXFIFO_DEPTH+1);
   localparam logic [32:0] RAM_BYTES = 33'(DMEM_WORDS) * 33'd4;

   logic [31:0] r_ram [DMEM_WORDS];
   logic [31:0] r_cycles;
   logic [3:0]  r_fault;

   region_e     w_region;
   logic        w_access;
   logic        w_misalign;
   logic        w_is_rd;
   logic        w_is_wr;
   logic [3:0]  w_off;
   logic [AW-1:0] w_ram_idx;
   logic        w_mmio_wr;
   logic        w_push;
   logic        w_cyc_wr;
   logic        w_flt_clr;
   logic        w_full;
   logic        w_empty;
   logic        w_drop;
   logic [CW-1:0] w_count;
   logic [31:0] w_status;
   logic [3:0]  w_new_flt;
   logic [31:0] w_rdata;

   assign w_access   = bus.memread | bus.memwrite;
   assign w_misalign = (bus.mem_addr[1:0] != 2'b00);
   assign w_region   = decode_region(bus.mem_addr, MMIO_BASE[31:4], RAM_BYTES);
   // A simultaneous read+write is treated purely as a write.
   assign w_is_wr    = bus.memwrite;
   assign w_is_rd    = bus.memread & ~bus.memwrite;
   assign w_off      = bus.mem_addr[3:0];
   assign w_ram_idx  = bus.mem_addr[AW+1:2];

   assign w_mmio_wr  = w_is_wr & (w_region == REG_MMIO);
   assign w_push     = w_mmio_wr & (w_off == OFF_TXDATA);
   assign w_cyc_wr   = w_mmio_wr & (w_off == OFF_CYCLES);
   assign w_flt_clr  = w_mmio_wr & (w_off == OFF_FAULT);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TXFIFO_DEPTH)
   ) u_txfifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_data  (bus.mem_writedata[7:0]),
      .i_pop   (bus.tx_ready),
      .o_data  (bus.tx_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_drop  (w_drop)
   );

   assign bus.tx_valid = ~w_empty;
   assign w_status     = {23'b0, 5'(w_count), 2'b00, w_empty, w_full};

   always_ff @(posedge clk) begin
      if (w_is_wr && (w_region == REG_RAM)) r_ram[w_ram_idx] <= bus.mem_writedata;
   end

   always_comb begin
      w_rdata = '0;
      if (w_is_rd) begin
         case (w_region)
            REG_RAM:  w_rdata = r_ram[w_ram_idx];
            REG_MMIO: begin
               case (w_off)
                  OFF_TXSTATUS: w_rdata = w_status;
                  OFF_CYCLES:   w_rdata = r_cycles;
                  OFF_FAULT:    w_rdata = {28'b0, r_fault};
                  default:      w_rdata = '0;
               endcase
            end
            default:  w_rdata = '0;
         endcase
      end
   end

   assign bus.mem_readdata = w_rdata;

   always_comb begin
      w_new_flt               = '0;
      w_new_flt[FLT_MISALIGN] = w_access & w_misalign;
      w_new_flt[FLT_RANGE]    = w_access & ~w_misalign & (w_region == REG_BAD);
      w_new_flt[FLT_RW]       = bus.memread & bus.memwrite;
      w_new_flt[FLT_OVF]      = w_drop;
   end

   // A clear and a fault raised in the same cycle: the new fault survives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_fault <= '0;
      else        r_fault <= (w_flt_clr ? 4'b0 : r_fault) | w_new_flt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        r_cycles <= '0;
      else if (w_cyc_wr) r_cycles <= bus.mem_writedata;
      else               r_cycles <= r_cycles + 32'd1;
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: drivers queue expectations, a negedge
// monitor compares load data, tx_valid and every drained TX byte.
module tb_dmem_mmio;
   import mmio_pkg::*;

   localparam logic [31:0] BASE   = 32'hFFFF_0000;
   localparam logic [31:0] A_TXD  = BASE + 32'h0;
   localparam logic [31:0] A_TXS  = BASE + 32'h4;
   localparam logic [31:0] A_CYC  = BASE + 32'h8;
   localparam logic [31:0] A_FLT  = BASE + 32'hC;
   localparam int          K_RD   = 0;
   localparam int          K_TXV  = 1;

   logic clk;
   logic reset;

   dmem_mmio_if bus();

   dmem_mmio #(
      .DMEM_WORDS   (1024),
      .TXFIFO_DEPTH (8),
      .MMIO_BASE    (BASE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard
   logic [31:0] exp_q[$];
   int          kind_q[$];
   string       name_q[$];
   logic [7:0]  tx_q[$];
   int          chk_n;
   int          checks;
   int          failures;

   logic [31:0] m_exp;
   logic [31:0] m_act;
   int          m_kind;
   string       m_name;
   logic [7:0]  m_byte;

   always @(negedge clk) begin
      for (int i = 0; i < chk_n; i++) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow: got empty queue expected item");
         end else begin
            m_exp  = exp_q.pop_front();
            m_kind = kind_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = (m_kind == K_TXV) ? {31'b0, bus.tx_valid} : bus.mem_readdata;
            if (m_act !== m_exp) begin
               failures++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", m_name, m_act, m_exp);
            end
         end
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
         checks++;
         if (tx_q.size() == 0) begin
            failures++;
            $display("FAIL tx_unexpected: got 0x%02h expected no byte", bus.tx_data);
         end else begin
            m_byte = tx_q.pop_front();
            if (bus.tx_data !== m_byte) begin
               failures++;
               $display("FAIL tx_byte: got 0x%02h expected 0x%02h", bus.tx_data, m_byte);
            end
         end
      end
   end

   // Driver tasks
   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
      bus.memread       = rd;
      bus.memwrite      = wr;
      bus.mem_addr      = addr;
      bus.mem_writedata = data;
   endtask

   task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
      exp_q.push_back(exp);
      kind_q.push_back(kind);
      name_q.push_back(name);
      chk_n++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk_n = 0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      drive(1'b0, 1'b1, addr, data);
      step();
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      drive(1'b1, 1'b0, addr, 32'h0);
      expect_val(K_RD, exp, name);
      step();
   endtask

   task automatic txv(input logic exp, input string name);
      expect_val(K_TXV, {31'b0, exp}, name);
      step();
   endtask

   task automatic tx_push(input logic [7:0] b, input logic expect_out);
      if (expect_out) tx_q.push_back(b);
      wr(A_TXD, {24'h0, b});
   endtask

   // Stimulus
   initial begin
      checks       = 0;
      failures     = 0;
      chk_n        = 0;
      reset        = 1'b0;
      bus.tx_ready = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      drive(1'b1, 1'b0, A_CYC, 32'h0);
      expect_val(K_RD, 32'h0, "rst_cycles");
      expect_val(K_TXV, 32'h0, "rst_txv");
      step();
      reset = 1'b1;

      rd(A_FLT, 32'h0, "rst_fault");
      rd(A_TXS, 32'h2, "rst_txstatus");
      rd(A_CYC, 32'h2, "free_run_cycles");
      rd(A_TXD, 32'h0, "txdata_read_zero");

      // RAM round trip (0x44 preloaded with zero)
      wr(32'h44, 32'h0);
      wr(32'h40, 32'hDEAD_BEEF);
      rd(32'h40, 32'hDEAD_BEEF, "ram_rt");
      rd(32'h44, 32'h0, "ram_unwritten");

      // Misaligned / out-of-range / read+write together
      wr(32'h41, 32'h1234_5678);
      rd(32'h40, 32'hDEAD_BEEF, "misalign_dropped");
      rd(A_FLT, 32'h1, "flt_misalign");
      wr(A_FLT, 32'h0);
      rd(32'h0000_1000, 32'h0, "oor_read");
      rd(A_FLT, 32'h2, "flt_range");
      wr(A_FLT, 32'h0);
      drive(1'b1, 1'b1, 32'h48, 32'h0000_1234);
      expect_val(K_RD, 32'h0, "rw_readdata");
      step();
      rd(32'h48, 32'h0000_1234, "rw_as_write");
      rd(A_FLT, 32'h4, "flt_rw");
      wr(A_FLT, 32'hFFFF_FFFF);

      // Fill, overflow, drain
      for (int i = 0; i < 8; i++) tx_push(8'h41 + 8'(i), 1'b1);
      rd(A_TXS, 32'h81, "tx_full_status");
      tx_push(8'h49, 1'b0);
      rd(A_FLT, 32'h8, "flt_overflow");
      rd(A_TXS, 32'h81, "tx_unchanged");
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) txv(1'b1, "drain_valid");
      txv(1'b0, "drained_invalid");
      rd(A_TXS, 32'h2, "drained_status");

      // Full + pop + push in the same cycle
      bus.tx_ready = 1'b0;
      wr(A_FLT, 32'h0);
      for (int i = 0; i < 8; i++) tx_push(8'h61 + 8'(i), 1'b1);
      bus.tx_ready = 1'b1;
      tx_push(8'h5A, 1'b1);
      bus.tx_ready = 1'b0;
      rd(A_TXS, 32'h81, "boundary_count");
      rd(A_FLT, 32'h0, "boundary_no_ovf");
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) txv(1'b1, "boundary_valid");
      txv(1'b0, "boundary_empty");
      bus.tx_ready = 1'b0;

      // Counter load and wrap
      wr(A_CYC, 32'hFFFF_FFFE);
      rd(A_CYC, 32'hFFFF_FFFE, "cyc_load");
      rd(A_CYC, 32'hFFFF_FFFF, "cyc_max");
      rd(A_CYC, 32'h0, "cyc_wrap");

      // Asynchronous reset between edges
      tx_push(8'h58, 1'b0);
      tx_push(8'h59, 1'b0);
      tx_push(8'h57, 1'b0);
      wr(32'h41, 32'h0);
      wr(A_CYC, 32'd100);
      rd(A_CYC, 32'd100, "cyc_100");
      txv(1'b1, "pre_rst_valid");
      reset = 1'b0;
      drive(1'b1, 1'b0, A_CYC, 32'h0);
      expect_val(K_RD, 32'h0, "async_rst_cycles");
      expect_val(K_TXV, 32'h0, "async_rst_txv");
      @(negedge clk);
      #1;
      reset = 1'b1;
      step();
      rd(A_CYC, 32'h1, "post_rst_cycles");
      rd(A_FLT, 32'h0, "post_rst_fault");
      txv(1'b0, "post_rst_txv");
      rd(32'h40, 32'hDEAD_BEEF, "ram_retained");

      repeat (2) step();
      checks++;
      if (tx_q.size() != 0) begin
         failures++;
         $display("FAIL tx_leftover: got %0d bytes expected 0", tx_q.size());
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL exp_leftover: got %0d items expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
